fd_delay_line_programmer: RTL and testbench
===========================================

FD_DELAY_LINE_PROGRAMMER -- requirements
Module: fd_delay_line_programmer

Interface
REQ-001 SHALL have parameter g_num_channels, default 4: number of programmable delay-line chips driven (1..8).
REQ-002 SHALL have parameter g_setup_cycles, default 2: cycles delay_val_o is stable before the LEN rising edge (>=1).
REQ-003 SHALL have parameter g_len_cycles, default 2: width of the LEN pulse in cycles (>=1).
REQ-004 SHALL have parameter g_hold_cycles, default 2: cycles delay_val_o is held after the LEN falling edge (>=1).
REQ-005 SHALL have port clk_ref_i  in  1: single reference clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n_i  in  1: reset, synchronous, active-low.
REQ-007 SHALL have port req_i  in  g_num_channels: per-channel program request, level, held until acked.
REQ-008 SHALL have port value_i  in  10*g_num_channels: per-channel tap value; channel k occupies bits [10k+9:10k].
REQ-009 SHALL have port ack_o  out  g_num_channels: one-cycle completion pulse per channel.
REQ-010 SHALL have port busy_o  out  1: high whenever the FSM is not in IDLE.
REQ-011 SHALL have port delay_val_o  out  10: shared tap bus to all delay chips.
REQ-012 SHALL have port delay_len_o  out  g_num_channels: per-chip latch enable; the chip captures on its rising edge.

Function
REQ-013 SHALL implement the states IDLE, SETUP, STROBE and HOLD, with IDLE->SETUP on grant, SETUP->STROBE after g_setup_cycles, STROBE->HOLD after g_len_cycles, and HOLD->IDLE after g_hold_cycles.
REQ-014 SHALL sample req_i in IDLE only, grant one channel round-robin starting at the channel after the last granted one (channel 0 first after reset), and latch that channel's value_i into delay_val_o on the grant edge.
REQ-015 SHALL ignore value_i changes after the grant and keep delay_val_o constant through SETUP, STROBE and HOLD.
REQ-016 SHALL drive only the granted bit of delay_len_o high, and only during STROBE; no two LEN bits are ever high together.
REQ-017 SHALL pulse ack_o of the granted channel for exactly one cycle, in the first IDLE cycle after HOLD.
REQ-018 SHALL mask the just-acked channel from arbitration during its ack cycle, so a requester that drops req_i on ack is not re-served.
REQ-019 SHALL give a latency from the req_i sampled edge to ack_o of g_setup_cycles+g_len_cycles+g_hold_cycles+1 cycles (7 at defaults) when idle.
REQ-020 SHALL ignore a req_i deasserted before grant, with no ack for that channel.
REQ-021 SHALL keep delay_val_o at the last programmed value while in IDLE.

Reset
REQ-022 SHALL on rst_n_i low at a clock edge force IDLE, delay_len_o=0, ack_o=0, busy_o=0, delay_val_o=0, and the round-robin pointer to channel 0, including mid-transaction with no ack issued.

Configuration
REQ-023 SHALL, with macro FD_DLY_READBACK_EN defined, add output readback_o (10*g_num_channels) holding per-channel shadow values, updated on the ack cycle and reset to 0; without the macro the port and shadow registers SHALL be absent.

Structure
REQ-024 SHALL place the FSM state enum, the 10-bit tap-value typedef and the tap-width constant in the shared package fd_delay_pkg.
REQ-025 SHALL implement arbitration in the sub-module fd_rr_arbiter (request vector, mask, pointer in; one-hot grant out).

Verification
REQ-026 SHALL cover: idle, req_i[2]=1 with value 10'h155 -> delay_val_o=0x155 one cycle later, delay_len_o[2] high for cycles 3-4, ack_o[2] at cycle 7.
REQ-027 SHALL cover: req_i=4'b1111 held -> grants in order 0,1,2,3,0, with each LEN pulse 2 cycles and never overlapping.
REQ-028 SHALL cover: value_i[0] changed from 0x3FF to 0x001 during STROBE -> delay_val_o stays 0x3FF until the next grant.
REQ-029 SHALL cover: rst_n_i low for 1 cycle during STROBE of ch1 -> next cycle all outputs 0, no ack_o[1], and a later req_i[3] is served first.
REQ-030 SHALL cover: req_i[1] pulsed for 1 cycle while busy -> no grant and no ack_o[1].
REQ-031 SHALL cover: with FD_DLY_READBACK_EN, programming ch3=0x2A0 -> readback_o[39:30]=0x2A0 from the ack cycle, other channels unchanged.

Source files
------------

// File: rtl/fd_delay_pkg.sv
// Shared definitions for the delay-line programmer: tap width, tap value
// type, FSM state encoding and the round-robin pointer helper.
// Imported by fd_rr_arbiter and fd_delay_line_programmer.
package fd_delay_pkg;

   // Width of one delay-chip tap value.
   localparam int TAP_W = 10;

   typedef logic [TAP_W-1:0] tap_t;

   // Programming sequence: latch the value, wait for setup, strobe LEN,
   // then hold the value stable before returning to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } fd_state_e;

   // Channel index following idx, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fd_delay_line_programmer_if.sv
// Host-side bundle of the delay-line programmer: per-channel requests and
// tap values in; acks, busy flag, shared tap bus and per-chip LEN out.
//
// Handshake: req[k] is a level that the requester holds, together with a
// stable value slice k, until ack[k] pulses for one cycle; the programmer
// samples requests only while idle, so a request dropped before it is
// granted is simply forgotten and never acked.
interface fd_delay_line_programmer_if #(
   parameter int g_num_channels = 4
);
   import fd_delay_pkg::*;

   logic [g_num_channels-1:0]       req;
   logic [TAP_W*g_num_channels-1:0] value;
   logic [g_num_channels-1:0]       ack;
   logic                            busy;
   logic [TAP_W-1:0]                delay_val;
   logic [g_num_channels-1:0]       delay_len;

   // Requesting side (host / testbench).
   modport master (
      output req,
      output value,
      input  ack,
      input  busy,
      input  delay_val,
      input  delay_len
   );

   // Serving side (programmer).
   modport slave (
      input  req,
      input  value,
      output ack,
      output busy,
      output delay_val,
      output delay_len
   );

endinterface

// File: rtl/fd_rr_arbiter.sv
// Round-robin arbiter: scans the unmasked requests starting at the pointer
// channel and wrapping, and returns a one-hot grant plus its index.
// Purely combinational; the caller owns the pointer register.
module fd_rr_arbiter
   import fd_delay_pkg::*;
#(
   parameter int g_num_channels = 4,
   parameter int g_idx_w        = 2
) (
   input  logic [g_num_channels-1:0] req_i,
   input  logic [g_num_channels-1:0] mask_i,
   input  logic [g_idx_w-1:0]        ptr_i,
   output logic [g_num_channels-1:0] grant_o,
   output logic [g_idx_w-1:0]        grant_idx_o,
   output logic                      grant_vld_o
);

   logic [g_num_channels-1:0] eligible;
   logic [g_idx_w-1:0]        scan_idx;
   int                        scan_int;

   // First eligible request at or after the pointer, wrapping around.
   always_comb begin
      eligible    = req_i & ~mask_i;
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      scan_int    = 0;
      scan_idx    = '0;
      for (int i = 0; i < g_num_channels; i++) begin
         scan_int = int'(ptr_i) + i;
         if (scan_int >= g_num_channels) begin
            scan_int = scan_int - g_num_channels;
         end
         scan_idx = g_idx_w'(scan_int);
         if (!grant_vld_o && eligible[scan_idx]) begin
            grant_vld_o        = 1'b1;
            grant_o[scan_idx]  = 1'b1;
            grant_idx_o        = scan_idx;
         end
      end
   end

endmodule

// File: rtl/fd_delay_line_programmer.sv
// Programs up to eight delay-line chips over a shared 10-bit tap bus.
// One channel at a time is granted round-robin; its tap value is latched,
// held for a setup time, strobed into the chip with a LEN pulse on that
// chip only, held again, and the requester is acked for one cycle.
// Optional feature: define FD_DLY_READBACK_EN to add readback_o, a set of
// per-channel shadow registers holding the last value programmed into
// each chip.
module fd_delay_line_programmer
   import fd_delay_pkg::*;
#(
   parameter int g_num_channels = 4,
   parameter int g_setup_cycles = 2,
   parameter int g_len_cycles   = 2,
   parameter int g_hold_cycles  = 2
) (
   input  logic                            clk_ref_i,
   input  logic                            rst_n_i,
   input  logic [g_num_channels-1:0]       req_i,
   input  logic [TAP_W*g_num_channels-1:0] value_i,
   output logic [g_num_channels-1:0]       ack_o,
   output logic                            busy_o,
   output logic [TAP_W-1:0]                delay_val_o,
   output logic [g_num_channels-1:0]       delay_len_o
`ifdef FD_DLY_READBACK_EN
   ,
   output logic [TAP_W*g_num_channels-1:0] readback_o
`endif
);

   localparam int IDX_W = (g_num_channels > 1) ? $clog2(g_num_channels) : 1;
   localparam int CNT_W = 16;

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_SETUP  = ST_SETUP;
   localparam logic [1:0] S_STROBE = ST_STROBE;
   localparam logic [1:0] S_HOLD   = ST_HOLD;

   // Last count value of each timed phase.
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(g_setup_cycles - 1);
   localparam logic [CNT_W-1:0] LEN_LAST   = CNT_W'(g_len_cycles - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(g_hold_cycles - 1);

   logic [1:0]                state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [g_num_channels-1:0] sel_q, sel_d;     // one-hot granted channel
   logic [IDX_W-1:0]          ptr_q, ptr_d;     // first channel to scan
   tap_t                      val_q, val_d;
   logic [g_num_channels-1:0] ack_q, ack_d;

   logic [g_num_channels-1:0] arb_req;
   logic [g_num_channels-1:0] arb_grant;
   logic [IDX_W-1:0]          arb_idx;
   logic                      arb_vld;
   tap_t                      granted_val;
   logic                      hold_done;

   // Requests only count while idle; the channel being acked this cycle
   // is masked so a requester that drops req on its ack is not re-served.
   assign arb_req   = (state_q == S_IDLE) ? req_i : '0;
   assign hold_done = (state_q == S_HOLD) && (cnt_q == HOLD_LAST);

   fd_rr_arbiter #(
      .g_num_channels (g_num_channels),
      .g_idx_w        (IDX_W)
   ) u_arb (
      .req_i       (arb_req),
      .mask_i      (ack_q),
      .ptr_i       (ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx),
      .grant_vld_o (arb_vld)
   );

   // Select the tap value of the channel being granted.
   always_comb begin
      granted_val = '0;
      for (int k = 0; k < g_num_channels; k++) begin
         if (arb_grant[k]) begin
            granted_val = value_i[k*TAP_W +: TAP_W];
         end
      end
   end

   // Sequencer: grant, timed setup/strobe/hold phases, ack on return to IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      val_d   = val_q;
      ack_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (arb_vld) begin
               state_d = S_SETUP;
               cnt_d   = '0;
               sel_d   = arb_grant;
               ptr_d   = IDX_W'(rr_next(int'(arb_idx), g_num_channels));
               val_d   = granted_val;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = S_STROBE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STROBE: begin
            if (cnt_q == LEN_LAST) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (hold_done) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               ack_d   = sel_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_ref_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         val_q   <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         val_q   <= val_d;
         ack_q   <= ack_d;
      end
   end

   // LEN comes straight from registered state, so it is glitch-free and
   // at most one bit (the granted one) is ever high.
   assign delay_len_o = (state_q == S_STROBE) ? sel_q : '0;
   assign delay_val_o = val_q;
   assign busy_o      = (state_q != S_IDLE);
   assign ack_o       = ack_q;

`ifdef FD_DLY_READBACK_EN
   logic [TAP_W*g_num_channels-1:0] shadow_q, shadow_d;

   // Shadow copy written as the sequence completes, visible with the ack.
   always_comb begin
      shadow_d = shadow_q;
      if (hold_done) begin
         for (int k = 0; k < g_num_channels; k++) begin
            if (sel_q[k]) begin
               shadow_d[k*TAP_W +: TAP_W] = val_q;
            end
         end
      end
   end

   // Shadow registers cleared by reset.
   always_ff @(posedge clk_ref_i) begin
      if (!rst_n_i) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign readback_o = shadow_q;
`endif

endmodule

// File: tb/tb_fd_delay_line_programmer.sv
// Self-checking bench for fd_delay_line_programmer (default parameters).
// Expected acks are queued as requests are driven and retired when the
// DUT acks; readback checks are compiled in with FD_DLY_READBACK_EN.
`timescale 1ns/1ps
module tb_fd_delay_line_programmer;
   import fd_delay_pkg::*;

   localparam int N = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fd_delay_line_programmer_if #(.g_num_channels(N)) dl_if ();

`ifdef FD_DLY_READBACK_EN
   logic [TAP_W*N-1:0] readback;
`endif

   fd_delay_line_programmer #(
      .g_num_channels (N),
      .g_setup_cycles (2),
      .g_len_cycles   (2),
      .g_hold_cycles  (2)
   ) dut (
      .clk_ref_i   (clk),
      .rst_n_i     (rst_n),
      .req_i       (dl_if.req),
      .value_i     (dl_if.value),
      .ack_o       (dl_if.ack),
      .busy_o      (dl_if.busy),
      .delay_val_o (dl_if.delay_val),
      .delay_len_o (dl_if.delay_len)
`ifdef FD_DLY_READBACK_EN
      ,
      .readback_o  (readback)
`endif
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int ch);
      logic [N-1:0] r;
      r = '0;
      r[ch] = 1'b1;
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   // Entry: {channel[3:0], tap value[9:0]} in expected ack order.
   logic [13:0] exp_q[$];
   logic [13:0] mon_e;
   logic [13:0] mon_f;
   logic [9:0]  model_val = '0;
   logic [9:0]  model_shadow[N];
   int          ack_cnt = 0;
   int          ack_per_ch[N];
   int          last_ack_cyc = 0;
   int          len_rise_cyc = 0;
   int          len_run = 0;
   logic [TAP_W*N-1:0] rb_exp;

   initial begin
      for (int k = 0; k < N; k++) begin
         model_shadow[k] = '0;
         ack_per_ch[k] = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         len_run = 0;
      end else begin
         if (dl_if.ack != '0) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_ack", 64'(dl_if.ack), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("ack_channel", 64'(dl_if.ack), 64'(onehot(int'(mon_e[13:10]))));
               check_eq("ack_value", 64'(dl_if.delay_val), 64'(mon_e[9:0]));
               model_val = mon_e[9:0];
               ack_cnt++;
               ack_per_ch[int'(mon_e[13:10])]++;
               last_ack_cyc = cyc;
`ifdef FD_DLY_READBACK_EN
               model_shadow[int'(mon_e[13:10])] = mon_e[9:0];
               for (int k = 0; k < N; k++) rb_exp[k*TAP_W +: TAP_W] = model_shadow[k];
               check_eq("readback", 64'(readback), 64'(rb_exp));
`endif
            end
         end
         if (dl_if.busy) begin
            if (exp_q.size() == 0) begin
               check_eq("busy_without_request", 64'(dl_if.busy), 64'd0);
            end else begin
               mon_f = exp_q[0];
               check_eq("val_stable", 64'(dl_if.delay_val), 64'(mon_f[9:0]));
               if (dl_if.delay_len != '0)
                  check_eq("len_onehot", 64'(dl_if.delay_len), 64'(onehot(int'(mon_f[13:10]))));
            end
         end else begin
            check_eq("idle_val", 64'(dl_if.delay_val), 64'(model_val));
            check_eq("idle_len", 64'(dl_if.delay_len), 64'd0);
         end
         if (dl_if.delay_len != '0) begin
            if (len_run == 0) len_rise_cyc = cyc;
            len_run++;
         end else if (len_run != 0) begin
            check_eq("len_width", 64'(len_run), 64'd2);
            len_run = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_acks(input int target, input int budget);
      int n;
      n = 0;
      while (ack_cnt < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq("ack_arrived", 64'(ack_cnt >= target), 64'd1);
   endtask

   // Program one channel; optionally change its value_i once LEN is seen.
   task automatic prog(input int ch, input logic [9:0] val, input bit poke,
                       input logic [9:0] poke_val, output int lat);
      int start;
      int target;
      int n;
      @(posedge clk);
      #1;
      dl_if.value[ch*TAP_W +: TAP_W] = val;
      dl_if.req[ch] = 1'b1;
      exp_q.push_back({4'(ch), val});
      start  = cyc;
      target = ack_cnt + 1;
      n = 0;
      while (ack_cnt < target && n < 100) begin
         @(negedge clk);
         #1;
         if (poke && dl_if.delay_len != '0) dl_if.value[ch*TAP_W +: TAP_W] = poke_val;
         n++;
      end
      check_eq("prog_ack_arrived", 64'(ack_cnt >= target), 64'd1);
      dl_if.req[ch] = 1'b0;
      lat = last_ack_cyc - start;
   endtask

   task automatic clear_model();
      exp_q.delete();
      model_val = '0;
      for (int k = 0; k < N; k++) model_shadow[k] = '0;
   endtask

   // ---------------- stimulus ----------------
   int lat;
   int ch1_acks;
   int n;
   int rch;
   logic [9:0] rval;

   initial begin
      dl_if.req   = '0;
      dl_if.value = '0;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy", 64'(dl_if.busy), 64'd0);
      check_eq("rst_len", 64'(dl_if.delay_len), 64'd0);
      check_eq("rst_ack", 64'(dl_if.ack), 64'd0);
      check_eq("rst_val", 64'(dl_if.delay_val), 64'd0);
      rst_n = 1'b1;

      // All four channels requesting: served 0,1,2,3,0.
      @(posedge clk);
      #1;
      dl_if.value = {10'h3C3, 10'h2C2, 10'h1C1, 10'h0C0};
      exp_q.push_back({4'd0, 10'h0C0});
      exp_q.push_back({4'd1, 10'h1C1});
      exp_q.push_back({4'd2, 10'h2C2});
      exp_q.push_back({4'd3, 10'h3C3});
      exp_q.push_back({4'd0, 10'h0C0});
      dl_if.req = 4'b1111;
      wait_acks(ack_cnt + 5, 200);
      dl_if.req = '0;
      repeat (3) @(posedge clk);

      // Single idle request: value next cycle, LEN in cycles 3-4, ack at 7.
      prog(2, 10'h155, 1'b0, 10'h0, lat);
      check_eq("latency_ch2", 64'(lat), 64'd7);
      check_eq("len_rise_ch2", 64'(len_rise_cyc - (last_ack_cyc - 7)), 64'd3);
      repeat (2) @(posedge clk);

      // value_i changed during STROBE must not reach delay_val_o.
      prog(0, 10'h3FF, 1'b1, 10'h001, lat);
      repeat (3) @(negedge clk);
      check_eq("val_kept_idle", 64'(dl_if.delay_val), 64'h3FF);

      // One-cycle req[1] pulse while busy with ch3: never served.
      ch1_acks = ack_per_ch[1];
      fork
         prog(3, 10'h0AB, 1'b0, 10'h0, lat);
         begin
            repeat (3) @(posedge clk);
            #1 dl_if.req[1] = 1'b1;
            @(posedge clk);
            #1 dl_if.req[1] = 1'b0;
         end
      join
      repeat (10) @(negedge clk);
      check_eq("no_ack_ch1_pulse", 64'(ack_per_ch[1]), 64'(ch1_acks));

      // Reset during STROBE of ch1: everything clears, no ack for ch1.
      @(posedge clk);
      #1;
      dl_if.value[1*TAP_W +: TAP_W] = 10'h111;
      dl_if.req[1] = 1'b1;
      exp_q.push_back({4'd1, 10'h111});
      n = 0;
      while (dl_if.delay_len == '0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq("strobe_ch1", 64'(dl_if.delay_len), 64'b0010);
      ch1_acks = ack_per_ch[1];
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      dl_if.req = '0;
      clear_model();
      @(posedge clk);
      @(negedge clk);
      check_eq("midrst_len", 64'(dl_if.delay_len), 64'd0);
      check_eq("midrst_ack", 64'(dl_if.ack), 64'd0);
      check_eq("midrst_busy", 64'(dl_if.busy), 64'd0);
      check_eq("midrst_val", 64'(dl_if.delay_val), 64'd0);
`ifdef FD_DLY_READBACK_EN
      check_eq("midrst_readback", 64'(readback), 64'd0);
`endif
      rst_n = 1'b1;

      // Request on ch3 after the reset is the first one served.
      prog(3, 10'h2A0, 1'b0, 10'h0, lat);
      check_eq("latency_ch3", 64'(lat), 64'd7);
      check_eq("no_ack_ch1_rst", 64'(ack_per_ch[1]), 64'(ch1_acks));
`ifdef FD_DLY_READBACK_EN
      check_eq("readback_ch3", 64'(readback[39:30]), 64'h2A0);
      check_eq("readback_others", 64'(readback[29:0]), 64'd0);
`endif

      // A few random single-channel programs.
      for (int i = 0; i < 6; i++) begin
         rch  = int'($urandom_range(0, N - 1));
         rval = 10'($urandom_range(0, 1023));
         prog(rch, rval, 1'b0, 10'h0, lat);
         check_eq("latency_rand", 64'(lat), 64'd7);
      end
      repeat (5) @(negedge clk);
      check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
